// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin sharing of one alu between two valid/ready requesters
// Optional: ALU_ARB_MUL_EN makes opcode 2 (mul) legal; otherwise it is rejected with rsp_err.
module alu_req_arbiter #(
  parameter int WIDTH       = 32,
  parameter int OPW         = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [OPW-1:0]   req_op_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [OPW-1:0]   req_op_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
`ifdef ALU_ARB_MUL_EN
  localparam logic [OPW-1:0] OP_MUL = OPW'(2);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant_valid;
  logic             grant_id;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  function automatic logic op_legal(input logic [OPW-1:0] op);
`ifdef ALU_ARB_MUL_EN
    op_legal = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
`else
    op_legal = (op == OP_ADD) || (op == OP_SUB);
`endif
  endfunction

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    grant_valid = req_valid_0 | req_valid_1;
    grant_id    = (req_valid_0 & req_valid_1) ? ~last_grant_q : req_valid_1;
    req_ready_0 = (state_q == S_IDLE) & grant_valid & ~grant_id;
    req_ready_1 = (state_q == S_IDLE) & grant_valid &  grant_id;
    sel_op      = grant_id ? req_op_1 : req_op_0;
    sel_a       = grant_id ? req_a_1  : req_a_0;
    sel_b       = grant_id ? req_b_1  : req_b_0;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
          if (op_legal(sel_op)) begin
            alu_a_d    = sel_a;
            alu_b_d    = sel_b;
            alu_ctrl_d = sel_op;
            cnt_d      = CW'(WAIT_CYCLES - 1);
            state_d    = S_EXEC;
          end else begin
            // Illegal ops never reach the shared alu; answer straight away.
            rsp_data_d = '0;
            rsp_zero_d = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d = alu_res;
          rsp_zero_d = alu_zero;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - scoreboard bench for alu_req_arbiter with a behavioural alu and reference model
module tb_alu_req_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;
  localparam int WAIT  = 2;
`ifdef ALU_ARB_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid_0, req_ready_0, req_valid_1, req_ready_1;
  logic [OPW-1:0]   req_op_0, req_op_1;
  logic [WIDTH-1:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [OPW-1:0]   alu_ctrl;
  logic             alu_zero;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [WIDTH-1:0] rsp_data;

  always #5 clk = ~clk;

  alu_req_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
    .req_a_0(req_a_0), .req_b_0(req_b_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
    .req_a_1(req_a_1), .req_b_1(req_b_1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  // Stand-in for the shared alu; unknown opcodes give a poison value.
  always_comb begin
    case (alu_ctrl)
      4'd0:    alu_res = alu_a + alu_b;
      4'd1:    alu_res = alu_a - alu_b;
      4'd2:    alu_res = alu_a * alu_b;
      default: alu_res = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_a == alu_b);
  end

  typedef struct {
    bit          id;
    logic [31:0] data;
    bit          zero;
    bit          err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          m_last = 1'b1;
  logic [31:0] m_alu_a = '0, m_alu_b = '0;
  logic [3:0]  m_alu_ctrl = '0;
  bit          new_rsp = 1'b1;
  bit          acc_flag [2] = '{0, 0};
  bit          got [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (MUL_EN && op == 4'd2);
  endfunction

  function automatic exp_t predict(input bit id, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b, input int now);
    exp_t e;
    logic [63:0] full;
    e.id = id;
    if (!legal(op)) begin
      e.data = '0; e.zero = 1'b0; e.err = 1'b1; e.due = now + 1;
    end else begin
      if (op == 4'd0)      full = {32'd0, a} + {32'd0, b};
      else if (op == 4'd1) full = {32'd0, a} - {32'd0, b};
      else                 full = {32'd0, a} * {32'd0, b};
      e.data = full[31:0]; e.zero = (a == b); e.err = 1'b0; e.due = now + 1 + WAIT;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      automatic bit       m_busy = (sb.size() != 0);
      automatic logic [1:0] exp_rdy;
      exp_t e;
      check("alu_a_hold", alu_a, m_alu_a);
      check("alu_b_hold", alu_b, m_alu_b);
      check("alu_ctrl_hold", alu_ctrl, m_alu_ctrl);
      check("busy", busy, m_busy);
      if (m_busy)                          exp_rdy = 2'b00;
      else if (req_valid_0 && req_valid_1) exp_rdy = m_last ? 2'b01 : 2'b10;
      else if (req_valid_0)                exp_rdy = 2'b01;
      else if (req_valid_1)                exp_rdy = 2'b10;
      else                                 exp_rdy = 2'b00;
      check("ready_1_0", {req_ready_1, req_ready_0}, exp_rdy);
      if (!m_busy) begin
        check("spurious_rsp", rsp_valid, 1'b0);
      end else begin
        e = sb[0];
        if (new_rsp) begin
          check("rsp_timing", rsp_valid, cyc >= e.due);
          if (rsp_valid) new_rsp = 1'b0;
        end
        if (rsp_valid) begin
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
          check("rsp_zero", rsp_zero, e.zero);
          check("rsp_err", rsp_err, e.err);
          if (rsp_ready) begin
            void'(sb.pop_front());
            new_rsp = 1'b1;
          end
        end
      end
      if (req_valid_0 && req_ready_0) begin
        sb.push_back(predict(1'b0, req_op_0, req_a_0, req_b_0, cyc));
        m_last = 1'b0; grant_log.push_back(0); acc_flag[0] = 1'b1;
        if (legal(req_op_0)) begin m_alu_a = req_a_0; m_alu_b = req_b_0; m_alu_ctrl = req_op_0; end
      end else if (req_valid_1 && req_ready_1) begin
        sb.push_back(predict(1'b1, req_op_1, req_a_1, req_b_1, cyc));
        m_last = 1'b1; grant_log.push_back(1); acc_flag[1] = 1'b1;
        if (legal(req_op_1)) begin m_alu_a = req_a_1; m_alu_b = req_b_1; m_alu_ctrl = req_op_1; end
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin req_valid_0 = 1'b1; req_op_0 = op; req_a_0 = a; req_b_0 = b; end
    else        begin req_valid_1 = 1'b1; req_op_1 = op; req_a_1 = a; req_b_1 = b; end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (acc_flag[0]) begin acc_flag[0] = 1'b0; got[0] = 1'b1; req_valid_0 = 1'b0; end
    if (acc_flag[1]) begin acc_flag[1] = 1'b0; got[1] = 1'b1; req_valid_1 = 1'b0; end
  endtask

  task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    got[0] = 1'b0; got[1] = 1'b0;
    set_req(i, op, a, b);
    for (int k = 0; k < 100; k++) begin
      step();
      if (got[i]) return;
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0) return;
      step();
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  function automatic logic [3:0] rand_op();
    int r = $urandom_range(0, 9);
    if (r < 3) return 4'd0;
    if (r < 6) return 4'd1;
    if (r < 8) return 4'd2;
    if (r == 8) return 4'hF;
    return 4'($urandom_range(3, 14));
  endfunction

  task automatic rand_req(input int i);
    logic [31:0] a, b;
    a = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 300);
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = $urandom_range(0, 300);
      default: b = $urandom;
    endcase
    set_req(i, rand_op(), a, b);
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req_valid_0 = 1'b0; req_op_0 = '0; req_a_0 = '0; req_b_0 = '0;
    req_valid_1 = 1'b0; req_op_1 = '0; req_a_1 = '0; req_b_1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_rsp_data", rsp_data, 0);
    reset = 1'b0;
    step();

    rsp_ready = 1'b1;
    issue(0, 4'd0, 32'd3, 32'd4);
    step();
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_alu", {alu_a, alu_b}, 64'd0);
    check("midrst_ctrl", alu_ctrl, 0);
    check("midrst_rsp", {rsp_valid, rsp_err, rsp_zero, rsp_id}, 0);
    check("midrst_data", rsp_data, 0);
    check("midrst_ready", {req_ready_1, req_ready_0}, 0);
    sb.delete(); grant_log.delete();
    m_last = 1'b1; m_alu_a = '0; m_alu_b = '0; m_alu_ctrl = '0; new_rsp = 1'b1;
    acc_flag[0] = 1'b0; acc_flag[1] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) step();

    got[0] = 1'b0; got[1] = 1'b0;
    set_req(0, 4'd0, 32'd10, 32'd20);
    set_req(1, 4'd1, 32'd50, 32'd8);
    for (int k = 0; k < 200 && grant_log.size() < 4; k++) begin
      step();
      if (!req_valid_0) set_req(0, 4'd0, $urandom_range(0, 99), $urandom_range(0, 99));
      if (!req_valid_1) set_req(1, 4'd1, $urandom_range(0, 99), $urandom_range(0, 99));
      if (grant_log.size() >= 4) begin req_valid_0 = 1'b0; req_valid_1 = 1'b0; end
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    wait_idle();
    check("grant_count", grant_log.size(), 4);
    if (grant_log.size() >= 4)
      check("grant_order", {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}, 4'b0101);

    issue(0, 4'd0, 32'd5, 32'd7);
    wait_idle();

    rsp_ready = 1'b0;
    issue(1, 4'd1, 32'd9, 32'd9);
    set_req(0, 4'd0, 32'd1, 32'd1);
    repeat (WAIT + 6) step();
    req_valid_0 = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    issue(0, 4'd2, 32'd6, 32'd7);
    wait_idle();
    issue(1, 4'hF, 32'd1, 32'd2);
    wait_idle();
    issue(0, 4'd0, 32'd100, 32'd23);
    wait_idle();

    for (int k = 0; k < 3000; k++) begin
      step();
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid_0) begin
        if ($urandom_range(0, 2) == 0) rand_req(0);
      end else if ($urandom_range(0, 15) == 0) begin
        req_valid_0 = 1'b0;
      end
      if (!req_valid_1) begin
        if ($urandom_range(0, 2) == 0) rand_req(1);
      end else if ($urandom_range(0, 15) == 0) begin
        req_valid_1 = 1'b0;
      end
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0; rsp_ready = 1'b1;
    wait_idle();
    step();
    check("final_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
